pipe_skid_stage: RTL and testbench

- Parametrised successor to the fixed-field inter-stage pipeline registers (D/E/M/W).
- Carries an opaque DATA_W-bit payload between two CPU pipeline stages.
- Uses a valid/ready handshake instead of stall/bubble strobes, plus a synchronous flush.
- An optional 2-entry skid buffer registers in_ready_o, cutting the combinational ready path across stages.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_sat_counter.sv | 34 +++
 rtl/pipe_skid_stage.sv | 137 +++++++++++++
 tb/tb_pipe_skid_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage package: occupancy state encoding and
// performance-counter sizing used by pipe_skid_stage and pipe_sat_counter.
package pipe_pkg;

  // Number of valid entries held by a stage; doubles as the FSM state.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam int                    PERF_CNT_W   = 32;
  localparam logic [PERF_CNT_W-1:0] PERF_CNT_MAX = {PERF_CNT_W{1'b1}};

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the stage performance counters.
// Holds at all-ones once reached; cleared only by reset.
module pipe_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  output logic [W-1:0] value_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: step by one unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register; only written when an increment is requested.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer.
// SKID=1 registers in_ready_o (it depends on state only); SKID=0 is a single
// register with combinational ready. Optional performance counters are
// built only when PIPE_SKID_STAGE_PERF_EN is defined; otherwise the counter
// ports read zero. The port list is identical in both builds.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 128,
  parameter int                SKID       = 1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  input  logic              flush_i,
  output logic [1:0]        occupancy_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
);

  occ_e              state_q, state_d;
  logic [DATA_W-1:0] main_data_q;
  logic [DATA_W-1:0] skid_data_q;
  logic              main_v;
  logic              in_fire;
  logic              out_fire;
  logic              main_load;
  logic              main_from_skid;
  logic              skid_load;

  // The skid entry is only ever valid behind a valid main entry, so the
  // occupancy state alone tells us both valid bits.
  assign main_v   = (state_q != OCC_EMPTY);
  assign in_ready_o = (SKID != 0) ? (state_q != OCC_FULL)
                                  : (~main_v | out_ready_i);
  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = main_v & out_ready_i;

  // Next-state and payload-steering decisions; flush overrides everything.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush_i) begin
      state_d = OCC_EMPTY;
    end else begin
      unique case (state_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            state_d   = OCC_ONE;
            main_load = 1'b1;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            // Only reachable with a skid buffer: SKID=0 accepts while
            // full solely when the downstream is also taking the entry.
            if (SKID != 0) begin
              state_d   = OCC_FULL;
              skid_load = 1'b1;
            end
          end else if (out_fire) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (out_fire) begin
            state_d        = OCC_ONE;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  // Occupancy/valid state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload registers: loaded only on a transfer, so they hold still on
  // idle and stalled cycles.
  always_ff @(posedge clk_i) begin
    if (main_load) begin
      main_data_q <= in_data_i;
    end else if (main_from_skid) begin
      main_data_q <= skid_data_q;
    end
    if (skid_load) begin
      skid_data_q <= in_data_i;
    end
  end

  assign out_valid_o = main_v;
  assign out_data_o  = main_v ? main_data_q : BUBBLE_VAL;
  assign occupancy_o = state_q;

`ifdef PIPE_SKID_STAGE_PERF_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = main_v & ~out_ready_i;
  assign flush_inc = flush_i & main_v;

  pipe_sat_counter #(.W(PERF_CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (stall_inc),
    .value_o (stall_cnt_o)
  );

  pipe_sat_counter #(.W(PERF_CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (flush_inc),
    .value_o (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: one SKID=1 instance (A) and one
// SKID=0 instance (B), both with a non-zero bubble value.
module tb_pipe_skid_stage;

  localparam int          DW     = 16;
  localparam logic [15:0] BUBBLE = 16'hDEAD;

  logic          clk;
  logic          rst_n;

  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [1:0]    a_occ;
  logic [31:0]   a_stall_cnt, a_flush_cnt;

  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [1:0]    b_occ;
  logic [31:0]   b_stall_cnt, b_flush_cnt;

  int n_cmp;
  int n_err;

  pipe_skid_stage #(.DATA_W(DW), .SKID(1), .BUBBLE_VAL(BUBBLE)) dut_a (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_valid_i  (a_in_valid),
    .in_data_i   (a_in_data),
    .in_ready_o  (a_in_ready),
    .out_valid_o (a_out_valid),
    .out_data_o  (a_out_data),
    .out_ready_i (a_out_ready),
    .flush_i     (a_flush),
    .occupancy_o (a_occ),
    .stall_cnt_o (a_stall_cnt),
    .flush_cnt_o (a_flush_cnt)
  );

  pipe_skid_stage #(.DATA_W(DW), .SKID(0), .BUBBLE_VAL(BUBBLE)) dut_b (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_valid_i  (b_in_valid),
    .in_data_i   (b_in_data),
    .in_ready_o  (b_in_ready),
    .out_valid_o (b_out_valid),
    .out_data_o  (b_out_data),
    .out_ready_i (b_out_ready),
    .flush_i     (b_flush),
    .occupancy_o (b_occ),
    .stall_cnt_o (b_stall_cnt),
    .flush_cnt_o (b_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0; a_flush = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_flush = 1'b0;
    #2;
    chk("rst_a_valid", 32'(a_out_valid), 32'd0);
    chk("rst_a_data",  32'(a_out_data),  32'(BUBBLE));
    chk("rst_a_ready", 32'(a_in_ready),  32'd1);
    chk("rst_a_occ",   32'(a_occ),       32'd0);
    chk("rst_a_stall", a_stall_cnt,      32'd0);
    chk("rst_a_flush", a_flush_cnt,      32'd0);
    chk("rst_b_valid", 32'(b_out_valid), 32'd0);
    #10 rst_n = 1'b1;
    step();

    // Streaming 1..8 with downstream always ready.
    a_in_valid = 1'b1; a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_data = DW'(i);
      step();
      chk("str_data",  32'(a_out_data),  32'(i));
      chk("str_valid", 32'(a_out_valid), 32'd1);
      chk("str_occ",   32'(a_occ),       32'd1);
    end
    a_in_valid = 1'b0;
    step();
    chk("str_drain_valid", 32'(a_out_valid), 32'd0);
    chk("str_drain_data",  32'(a_out_data),  32'(BUBBLE));

    // Backpressure: 0x11, 0x22 accepted, 0x33 held upstream.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h11;
    step();
    chk("bp_ready1", 32'(a_in_ready), 32'd1);
    chk("bp_data1",  32'(a_out_data), 32'h11);
    a_in_data = 16'h22;
    step();
    chk("bp_full_ready", 32'(a_in_ready), 32'd0);
    chk("bp_full_occ",   32'(a_occ),      32'd2);
    a_in_data = 16'h33;
    step();
    chk("bp_hold_occ",  32'(a_occ),      32'd2);
    chk("bp_hold_data", 32'(a_out_data), 32'h11);
    a_out_ready = 1'b1;
    step();
    chk("bp_out2", 32'(a_out_data), 32'h22);
    chk("bp_occ2", 32'(a_occ),      32'd1);
    step();
    chk("bp_out3", 32'(a_out_data), 32'h33);
    a_in_valid = 1'b0;
    step();
    chk("bp_empty", 32'(a_out_valid), 32'd0);

    // Flush priority in FULL: head still transfers, incoming 0x44 dropped.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h11;
    step();
    a_in_data = 16'h22;
    step();
    chk("fl_pre_occ", 32'(a_occ), 32'd2);
    a_flush = 1'b1; a_in_data = 16'h44; a_out_ready = 1'b1;
    #1;
    chk("fl_head_valid", 32'(a_out_valid), 32'd1);
    chk("fl_head_data",  32'(a_out_data),  32'h11);
    step();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk("fl_occ",   32'(a_occ),       32'd0);
    chk("fl_valid", 32'(a_out_valid), 32'd0);
    chk("fl_data",  32'(a_out_data),  32'(BUBBLE));
    step();
    chk("fl_no44", 32'(a_out_valid), 32'd0);

`ifndef PIPE_SKID_STAGE_PERF_EN
    chk("noperf_a_stall", a_stall_cnt, 32'd0);
    chk("noperf_a_flush", a_flush_cnt, 32'd0);
`endif

    // Asynchronous reset in the middle of a FULL stage.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h000A;
    step();
    a_in_data = 16'h000B;
    step();
    a_in_valid = 1'b0;
    chk("mr_pre_occ", 32'(a_occ), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(a_out_valid), 32'd0);
    chk("mr_data",  32'(a_out_data),  32'(BUBBLE));
    chk("mr_ready", 32'(a_in_ready),  32'd1);
    chk("mr_occ",   32'(a_occ),       32'd0);
    #1 rst_n = 1'b1;

`ifdef PIPE_SKID_STAGE_PERF_EN
    // Stall/flush counting after the reset cleared the counters.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h1;
    step();
    a_in_data = 16'h2;
    step();
    a_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("pf_stall5", a_stall_cnt, 32'd5);
    chk("pf_flush0", a_flush_cnt, 32'd0);
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    chk("pf_flush_occ", 32'(a_occ), 32'd0);
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    chk("pf_stall6", a_stall_cnt, 32'd6);
    chk("pf_flush1", a_flush_cnt, 32'd1);
    a_in_valid = 1'b1; a_in_data = 16'h3;
    step();
    a_in_valid = 1'b0;
    force dut_a.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut_a.u_stall_cnt.cnt_q;
    for (int i = 0; i < 3; i++) step();
    chk("pf_sat", a_stall_cnt, 32'hFFFF_FFFF);
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
`else
    chk("noperf_b_stall", b_stall_cnt, 32'd0);
    chk("noperf_b_flush", b_flush_cnt, 32'd0);
`endif

    // SKID=0: combinational ready follows downstream ready.
    step();
    b_in_valid = 1'b1; b_in_data = 16'h5; b_out_ready = 1'b0;
    step();
    chk("s0_valid", 32'(b_out_valid), 32'd1);
    chk("s0_data5", 32'(b_out_data),  32'h5);
    chk("s0_ready_lo", 32'(b_in_ready), 32'd0);
    b_in_data = 16'h6;
    step();
    chk("s0_hold5", 32'(b_out_data), 32'h5);
    chk("s0_occ1",  32'(b_occ),      32'd1);
    b_out_ready = 1'b1;
    #1;
    chk("s0_ready_hi", 32'(b_in_ready), 32'd1);
    step();
    chk("s0_data6", 32'(b_out_data), 32'h6);
    chk("s0_occ",   32'(b_occ),      32'd1);
    b_in_valid = 1'b0;
    step();
    chk("s0_empty_valid", 32'(b_out_valid), 32'd0);
    chk("s0_empty_data",  32'(b_out_data),  32'(BUBBLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
